imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, registered immediate extender for the MIPS decode stage. It is the successor to the fixed 16→32 sign extender. It accepts an IN_W-bit immediate with a 2-bit mode and produces an OUT_W-bit operand in one of four formats: sign-extend, zero-extend, upper-load, or branch word offset. Both sides use a valid/ready handshake, and a two-entry output/skid buffer sustains one transfer per cycle under backpressure.

## Interface
- IN_W, 16, input immediate width; must be ≥ 2.
- OUT_W, 32, output operand width; must be ≥ IN_W + 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  wirein/mode are valid this cycle.
- in_ready  output  1  block can accept this cycle.
- wirein  input  IN_W  raw immediate.
- mode  input  2  extension mode, captured with wirein.
- out_valid  output  1  wireout/out_neg are valid.
- out_ready  input  1  consumer accepts this cycle.
- wireout  output  OUT_W  extended operand.
- out_neg  output  1  MSB of the captured wirein (immediate sign).

## Operation
- Modes, with X = wirein:
  - 2'b00 SIGN: X sign-extended to OUT_W.
  - 2'b01 ZERO: X zero-extended to OUT_W.
  - 2'b10 UPPER: X placed in bits [OUT_W-1 : OUT_W-IN_W]; the low OUT_W-IN_W bits are 0.
  - 2'b11 BRANCH: sign-extend X to OUT_W, shift left 2, keep the low OUT_W bits. Bits [1:0] are 0.
- The result is computed combinationally from wirein/mode at accept time and stored in registers. No input-side register holds raw data.
- Storage:
  - Output register: OR, with flag ov.
  - Skid register: SK, with flag sv.
  - Each holds {result, out_neg}.
- Accept: acc = in_valid & in_ready. Pop: pop = ov & out_ready.
- in_ready = ~sv & ~rst.
- Per-cycle update, when not in reset:
  - sv=1 and pop: OR←SK; sv←0; ov stays 1. acc is impossible in this state.
  - sv=1 and no pop: hold everything.
  - sv=0, acc, and (ov=0 or pop): OR←new; ov←1.
  - sv=0, acc, ov=1, no pop: SK←new; sv←1. OR is held.
  - sv=0, no acc, pop: ov←0. OR data is held (don't-care).
  - sv=0, no acc, no pop: hold.
- Ordering: strict FIFO. The SK contents always leave after the OR contents.
- Data stability: while out_valid=1 and out_ready=0, wireout and out_neg must not change.
- Unused mode values: none; all four encodings are defined.

## Timing
- Reset values while rst=1 and on the cycle after release:
  - ov=0, sv=0.
  - wireout=0, out_neg=0.
  - out_valid=0.
  - in_ready=0 during rst; it becomes 1 on the first cycle with rst=0.
- Reset mid-operation discards the contents of both OR and SK. Any in_valid asserted during rst is ignored.
- Latency: data accepted at edge N appears with out_valid=1 after edge N, and is consumable in cycle N+1.
- Throughput: one transfer per cycle while out_ready=1.
- Full condition:
  - A single stalled cycle with a new accept fills SK.
  - in_ready drops in the following cycle.
  - in_ready returns to 1 one cycle after the pop that drains SK.
- Simultaneous accept and pop with sv=0 and ov=1: new data goes directly to OR, and SK stays empty.
- out_valid = ov and in_ready = ~sv; both are driven from registers, except for the rst gating on in_ready.

## Test plan
- Mode sweep, wirein=16'hA4AA, out_ready=1:
  - SIGN→32'hFFFFA4AA, out_neg=1.
  - ZERO→32'h0000A4AA.
  - UPPER→32'hA4AA0000.
  - BRANCH→32'hFFFE92A8.
  - Each result appears one cycle after accept.
- Positive value, wirein=16'h1234:
  - SIGN→32'h00001234.
  - BRANCH→32'h000048D0.
  - out_neg=0.
- Backpressure:
  - Stream 16'h0001..16'h0008 (SIGN) with out_ready toggled 1,0,0,1,0,1...
  - Required: every value emerges exactly once, in order.
  - in_ready=0 only while SK is full.
  - wireout is stable while stalled.
- Skid fill and drain:
  - Hold out_ready=0 and offer two words A and B.
  - Required: A is in OR, B is in SK, and in_ready=0 from the next cycle.
  - Raise out_ready: A then B emerge on consecutive cycles, and in_ready=1 one cycle after A pops.
- Reset mid-operation:
  - With both entries full, assert rst for 1 cycle.
  - Required: out_valid=0, wireout=0, in_ready=0 during rst, then in_ready=1.
  - No stale word is ever emitted.
- Parameter variant IN_W=8, OUT_W=16, wirein=8'h80:
  - SIGN→16'hFF80.
  - ZERO→16'h0080.
  - UPPER→16'h8000.
  - BRANCH→16'hFE00.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender for the decode stage.
// It extends an IN_W-bit immediate to OUT_W bits in one of four formats:
// sign, zero, upper-load or branch word offset.
// An output register plus a one-entry skid register sustain one transfer per
// cycle under backpressure.
//
// Handshake: a word moves on a side only in a cycle where both valid and ready
// are high at the rising edge. The producer holds wirein/mode while in_valid is
// high and in_ready is low. The block holds wireout/out_neg stable while
// out_valid is high and out_ready is low. in_ready does not look at in_valid.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  wirein,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] wireout,
    output logic             out_neg
);

    localparam int PAD_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // Each entry holds {extended result, immediate sign}.
    logic [OUT_W:0] or_q, or_d;
    logic [OUT_W:0] sk_q, sk_d;
    logic           ov_q, ov_d;
    logic           sv_q, sv_d;

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] upper_val;
    logic [OUT_W-1:0] branch_val;
    logic [OUT_W-1:0] ext_val;
    logic [OUT_W:0]   new_entry;
    logic             acc;
    logic             pop;

    // Compute every extension format, then pick one by mode.
    always_comb begin
        sext_val   = {{PAD_W{wirein[IN_W-1]}}, wirein};
        zext_val   = {{PAD_W{1'b0}}, wirein};
        upper_val  = {wirein, {PAD_W{1'b0}}};
        branch_val = {sext_val[OUT_W-3:0], 2'b00};
        ext_val    = sext_val;
        case (mode)
            MODE_SIGN:   ext_val = sext_val;
            MODE_ZERO:   ext_val = zext_val;
            MODE_UPPER:  ext_val = upper_val;
            MODE_BRANCH: ext_val = branch_val;
            default:     ext_val = sext_val;
        endcase
        new_entry = {ext_val, wirein[IN_W-1]};
    end

    // Handshake decode. The skid slot being empty is the only accept condition.
    // in_ready is gated by rst so that words offered during reset are dropped.
    assign in_ready  = ~sv_q & ~rst;
    assign out_valid = ov_q;
    assign wireout   = or_q[OUT_W:1];
    assign out_neg   = or_q[0];
    assign acc       = in_valid & in_ready;
    assign pop       = ov_q & out_ready;

    // Next-state for the output and skid slots. Order is strict FIFO: the skid
    // entry always refills the output register before new data can enter.
    always_comb begin
        or_d = or_q;
        sk_d = sk_q;
        ov_d = ov_q;
        sv_d = sv_q;
        if (sv_q) begin
            if (pop) begin
                or_d = sk_q;
                sv_d = 1'b0;
            end
        end else if (acc) begin
            if (!ov_q || pop) begin
                or_d = new_entry;
                ov_d = 1'b1;
            end else begin
                sk_d = new_entry;
                sv_d = 1'b1;
            end
        end else if (pop) begin
            ov_d = 1'b0;
        end
    end

    // State registers. Reset clears both slots, including their data.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_q <= '0;
            sk_q <= '0;
            ov_q <= 1'b0;
            sv_q <= 1'b0;
        end else begin
            or_q <= or_d;
            sk_q <= sk_d;
            ov_q <= ov_d;
            sv_q <= sv_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed bench for imm_ext_pipe.
// It checks the default 16->32 instance and a small 8->16 instance.
module tb_imm_ext_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A: 16 -> 32 ----------------
  logic        in_valid, in_ready, out_valid, out_ready, out_neg;
  logic [15:0] wirein;
  logic [1:0]  mode;
  logic [31:0] wireout;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .wirein(wirein), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .wireout(wireout), .out_neg(out_neg)
  );

  // ---------------- DUT B: 8 -> 16 ----------------
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_neg;
  logic [7:0]  b_wirein;
  logic [1:0]  b_mode;
  logic [15:0] b_wireout;

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .wirein(b_wirein), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .wireout(b_wireout), .out_neg(b_out_neg)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word with out_ready=1, then check it one cycle later.
  task automatic send_check(input string tag, input logic [1:0] m, input logic [15:0] d,
                            input logic [31:0] exp_out, input logic exp_neg);
    in_valid  = 1'b1;
    wirein    = d;
    mode      = m;
    out_ready = 1'b1;
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, wireout, exp_out);
    check({tag, "_neg"}, out_neg, exp_neg);
  endtask

  task automatic send_check_b(input string tag, input logic [1:0] m, input logic [7:0] d,
                              input logic [15:0] exp_out);
    b_in_valid  = 1'b1;
    b_wirein    = d;
    b_mode      = m;
    b_out_ready = 1'b1;
    tick();
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_data"}, b_wireout, exp_out);
    check({tag, "_neg"}, b_out_neg, 1);
  endtask

  // ---------------- stimulus ----------------
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int sent;
    int cyc;
    logic stall_prev;
    logic [31:0] held;
    logic acc_m;
    logic pop_m;

    rst = 1'b1;
    in_valid = 1'b1; wirein = 16'h1234; mode = 2'b00; out_ready = 1'b0;
    b_in_valid = 1'b0; b_wirein = 8'h00; b_mode = 2'b00; b_out_ready = 1'b0;

    // Reset: in_valid asserted during rst is ignored.
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_wireout", wireout, 0);
    check("rst_out_neg", out_neg, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();
    check("rel_out_valid", out_valid, 0);
    check("rel_wireout", wireout, 0);

    // Mode sweep with a negative immediate.
    send_check("sign_neg",   2'b00, 16'hA4AA, 32'hFFFFA4AA, 1'b1);
    send_check("zero_neg",   2'b01, 16'hA4AA, 32'h0000A4AA, 1'b1);
    send_check("upper_neg",  2'b10, 16'hA4AA, 32'hA4AA0000, 1'b1);
    send_check("branch_neg", 2'b11, 16'hA4AA, 32'hFFFE92A8, 1'b1);
    // Positive immediate.
    send_check("sign_pos",   2'b00, 16'h1234, 32'h00001234, 1'b0);
    send_check("branch_pos", 2'b11, 16'h1234, 32'h000048D0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("sweep_drained", out_valid, 0);

    // Skid fill and drain: A=8001 SIGN, B=0002 ZERO.
    out_ready = 1'b0;
    in_valid = 1'b1; wirein = 16'h8001; mode = 2'b00;
    tick();
    check("skid_a_valid", out_valid, 1);
    check("skid_a_data", wireout, 32'hFFFF8001);
    check("skid_a_ready", in_ready, 1);
    wirein = 16'h0002; mode = 2'b01;
    tick();
    check("skid_full_ready", in_ready, 0);
    check("skid_full_data", wireout, 32'hFFFF8001);
    in_valid = 1'b0;
    tick();
    check("skid_hold_ready", in_ready, 0);
    check("skid_hold_data", wireout, 32'hFFFF8001);
    check("skid_hold_neg", out_neg, 1);
    out_ready = 1'b1;
    tick();
    check("skid_b_valid", out_valid, 1);
    check("skid_b_data", wireout, 32'h00000002);
    check("skid_b_neg", out_neg, 0);
    check("skid_b_ready", in_ready, 1);
    tick();
    check("skid_empty", out_valid, 0);

    // Backpressure stream 1..8 (SIGN) against an occupancy model.
    sent = 0;
    cyc = 0;
    stall_prev = 1'b0;
    held = '0;
    exp_q.delete();
    while ((sent < 8 || exp_q.size() > 0) && cyc < 60) begin
      in_valid  = (sent < 8);
      wirein    = 16'(sent + 1);
      mode      = 2'b00;
      out_ready = pat[cyc % 6];
      #1;
      check("bp_in_ready", in_ready, (exp_q.size() < 2));
      check("bp_out_valid", out_valid, (exp_q.size() > 0));
      if (stall_prev) check("bp_stable", wireout, held);
      pop_m = (exp_q.size() > 0) && out_ready;
      acc_m = in_valid && (exp_q.size() < 2);
      if (pop_m) begin
        check("bp_data", wireout, exp_q[0]);
        check("bp_neg", out_neg, 0);
        void'(exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held = wireout;
      if (acc_m) begin
        exp_q.push_back(32'(sent + 1));
        sent++;
      end
      tick();
      cyc++;
    end
    check("bp_complete", {32'(sent), 32'(exp_q.size())}, {32'd8, 32'd0});
    in_valid = 1'b0;
    #1;
    check("bp_idle", out_valid, 0);

    // Reset with both entries full.
    out_ready = 1'b0;
    in_valid = 1'b1; wirein = 16'h0C0C; mode = 2'b00;
    tick();
    wirein = 16'h0D0D;
    tick();
    check("mid_full", in_ready, 0);
    rst = 1'b1;
    wirein = 16'hEEEE;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_wireout", wireout, 0);
    check("mid_rst_neg", out_neg, 0);
    check("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rel_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_stale", out_valid, 0);
    end
    send_check("mid_after", 2'b01, 16'h00F0, 32'h000000F0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("mid_after_drain", out_valid, 0);

    // 8 -> 16 variant.
    send_check_b("b_sign",   2'b00, 8'h80, 16'hFF80);
    send_check_b("b_zero",   2'b01, 8'h80, 16'h0080);
    send_check_b("b_upper",  2'b10, 8'h80, 16'h8000);
    send_check_b("b_branch", 2'b11, 8'h80, 16'hFE00);
    b_in_valid = 1'b0;
    tick();
    check("b_drain", b_out_valid, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
